axi_rx_sink: RTL and testbench

AXI_RX_SINK -- requirements
Module: axi_rx_sink

---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_sync_fifo.sv | 53 +++++
 rtl/axi_rx_sink.sv | 122 ++++++++++++
 tb/tb_axi_rx_sink.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI receive sink: FLIT geometry, the layout of
// the per-FLIT flag fields inside the user word, and the framer state type.
package axi_pkg;

   localparam int FLIT_W = 128;

   // Flag fields inside the user word, each FPW bits wide, packed from bit 0
   localparam int USER_VALID = 0;
   localparam int USER_HDR   = 1;
   localparam int USER_TAIL  = 2;

   // Lowest bit of a flag field for a beat carrying fpw FLITs
   function automatic int user_field_lsb(input int fpw, input int field);
      return fpw * field;
   endfunction

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } framer_state_t;

endpackage

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO with occupancy output. Pushes at full and pops at empty
// are dropped, so the caller may drive push/pop from plain handshakes.
module axi_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & (count != LW'(DEPTH));
   assign do_pop  = pop & (count != '0);
   assign dout    = mem[rd_ptr];
   assign level   = count;

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_rx_sink.sv
// AXI-stream receive sink: buffers beats in a small FIFO and, when built with
// AXI_RX_SINK_STATS_EN defined, frames the FLIT flags of every accepted beat
// to count completed packets and flag framing errors.
//
// Framer states:
//   state     | meaning
//   ST_IDLE   | between packets, waiting for a header FLIT
//   ST_IN_PKT | header seen, waiting for the tail FLIT
module axi_rx_sink
   import axi_pkg::*;
#(
   parameter int DWIDTH         = 512,
   parameter int NUM_DATA_BYTES = 64,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   input  logic [DWIDTH-1:0]             rx_data,
   input  logic [NUM_DATA_BYTES-1:0]     rx_user,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DWIDTH-1:0]             out_data,
   output logic [NUM_DATA_BYTES-1:0]     out_user,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [15:0]                   pkt_count,
   output logic                          err_proto
);

   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int WIDTH = DWIDTH + NUM_DATA_BYTES;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] fifo_dout;

   // Ready comes from the registered level only: a pop at full does not open
   // a slot for a same-cycle push. Held low while reset is asserted.
   assign rx_ready  = ~res & (level < LW'(FIFO_DEPTH));
   assign out_valid = (level != '0);
   assign push      = rx_valid & rx_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = fifo_dout[WIDTH-1:NUM_DATA_BYTES];
   assign out_user  = fifo_dout[NUM_DATA_BYTES-1:0];

   axi_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (push),
      .pop   (pop),
      .din   ({rx_data, rx_user}),
      .dout  (fifo_dout),
      .level (level)
   );

`ifdef AXI_RX_SINK_STATS_EN
   localparam int FPW      = DWIDTH / FLIT_W;
   localparam int VLD_LSB  = user_field_lsb(FPW, USER_VALID);
   localparam int HDR_LSB  = user_field_lsb(FPW, USER_HDR);
   localparam int TAIL_LSB = user_field_lsb(FPW, USER_TAIL);
   localparam int INC_W    = $clog2(FPW + 1);

   framer_state_t    state_q;
   framer_state_t    state_d;
   logic [INC_W-1:0] pkt_inc;
   logic             err_hit;
   logic [15:0]      pkt_count_q;
   logic             err_q;
   logic [16:0]      pkt_sum;

   assign pkt_sum   = {1'b0, pkt_count_q} + 17'(pkt_inc);
   assign pkt_count = pkt_count_q;
   assign err_proto = err_q;

   // Framer state, saturating packet counter and sticky error flag
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q     <= ST_IDLE;
         pkt_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_count_q <= pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
         err_q       <= err_q | err_hit;
      end
   end

   // Walk the valid FLITs of an accepted beat in order; a FLIT's header is
   // applied before its tail so header+tail on one FLIT is a whole packet.
   always_comb begin
      state_d = state_q;
      pkt_inc = '0;
      err_hit = 1'b0;
      if (push) begin
         for (int i = 0; i < FPW; i++) begin
            if (rx_user[VLD_LSB+i]) begin
               if (rx_user[HDR_LSB+i]) begin
                  if (state_d == ST_IN_PKT) err_hit = 1'b1;
                  state_d = ST_IN_PKT;
               end
               if (rx_user[TAIL_LSB+i]) begin
                  if (state_d == ST_IN_PKT) begin
                     pkt_inc = pkt_inc + INC_W'(1);
                     state_d = ST_IDLE;
                  end else begin
                     err_hit = 1'b1;
                  end
               end
            end
         end
      end
   end
`else
   assign pkt_count = 16'h0000;
   assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rx_sink.sv
// Bench for axi_rx_sink: queue-based reference model, per-cycle comparison on
// the falling edge, directed scenarios with literal expectations, then random
// traffic and a packet-counter saturation run.
module tb_axi_rx_sink;

   localparam int DW    = 512;
   localparam int NB    = 64;
   localparam int DEPTH = 4;
   localparam int FPW   = DW / 128;

`ifdef AXI_RX_SINK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk;
   logic          res;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] rx_data;
   logic [NB-1:0] rx_user;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [NB-1:0] out_user;
   logic [2:0]    level;
   logic [15:0]   pkt_count;
   logic          err_proto;

   axi_rx_sink #(
      .DWIDTH         (DW),
      .NUM_DATA_BYTES (NB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .res       (res),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_user   (rx_user),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_user  (out_user),
      .level     (level),
      .pkt_count (pkt_count),
      .err_proto (err_proto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO contents as a queue, framer as a flag and counter
   logic [DW+NB-1:0] mq[$];
   bit               m_in_pkt = 1'b0;
   int               m_count = 0;
   bit               m_err = 1'b0;
   bit               m_push;
   bit               m_pop;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_beat(input string name, input logic [DW-1:0] d, input logic [NB-1:0] u,
                           input logic [DW-1:0] ed, input logic [NB-1:0] eu);
      checks++;
      if (d !== ed || u !== eu) begin
         errors++;
         $display("FAIL %s: got data %h user %h expected data %h user %h", name, d, u, ed, eu);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [NB-1:0] mk_user(input logic [3:0] v, input logic [3:0] h,
                                             input logic [3:0] t);
      logic [NB-1:0] u;
      u = {$urandom, $urandom};
      u[3:0]  = v;
      u[7:4]  = h;
      u[11:8] = t;
      return u;
   endfunction

   // Framing rules: header opens a packet (error if one is already open),
   // tail closes an open packet and counts it (error if none is open).
   task automatic model_frame(input logic [NB-1:0] u);
      for (int i = 0; i < FPW; i++) begin
         if (u[i]) begin
            if (u[FPW+i]) begin
               if (m_in_pkt) m_err = 1'b1;
               m_in_pkt = 1'b1;
            end
            if (u[2*FPW+i]) begin
               if (m_in_pkt) begin
                  if (m_count < 65535) m_count++;
                  m_in_pkt = 1'b0;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      end
   endtask

   // Model advances on each rising edge from the inputs presented before it
   always @(posedge clk) begin
      if (!res) begin
         m_push = rx_valid && (mq.size() < DEPTH);
         m_pop  = out_ready && (mq.size() > 0);
         if (m_pop) mq.delete(0);
         if (m_push) begin
            mq.push_back({rx_data, rx_user});
            model_frame(rx_user);
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      chk("rx_ready", 64'(rx_ready), 64'(!res && mq.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("level", 64'(level), 64'(mq.size()));
      chk("pkt_count", 64'(pkt_count), STATS ? 64'(m_count) : 64'd0);
      chk("err_proto", 64'(err_proto), STATS ? 64'(m_err) : 64'd0);
      if (mq.size() != 0)
         chk_beat("head", out_data, out_user, mq[0][DW+NB-1:NB], mq[0][NB-1:0]);
   end

   // One clock of stimulus: inputs change 1 ns after the rising edge
   task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [NB-1:0] u, input bit ordy);
      rx_valid  = v;
      rx_data   = d;
      rx_user   = u;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] d0;
   logic [NB-1:0] u0;

   initial begin
      res       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = '0;
      rx_user   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;
      #1;
      chk("rst_rx_ready", 64'(rx_ready), 64'd1);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);

      // Single complete packet across FLITs 0..3
      d0 = rand_data();
      u0 = mk_user(4'hF, 4'h1, 4'h8);
      cycle(1'b1, d0, u0, 1'b1);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk_beat("single_beat", out_data, out_user, d0, u0);
      chk("single_pkt", 64'(pkt_count), STATS ? 64'd1 : 64'd0);
      chk("single_err", 64'(err_proto), 64'd0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("single_drained", 64'(level), 64'd0);

      // Fill with consumer stalled: five offered, four accepted
      d0 = rand_data();
      u0 = mk_user(4'h0, 4'h0, 4'h0);
      cycle(1'b1, d0, u0, 1'b0);
      for (int k = 1; k < 5; k++) cycle(1'b1, rand_data(), mk_user(4'h0, 4'h0, 4'h0), 1'b0);
      chk("full_level", 64'(level), 64'd4);
      chk("full_ready", 64'(rx_ready), 64'd0);
      chk_beat("full_head", out_data, out_user, d0, u0);
      for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1);
      chk("drain_level", 64'(level), 64'd0);

      // At full, a same-cycle pop does not admit a push
      for (int k = 0; k < 4; k++) cycle(1'b1, rand_data(), mk_user(4'h0, 4'h0, 4'h0), 1'b0);
      cycle(1'b1, rand_data(), mk_user(4'h0, 4'h0, 4'h0), 1'b1);
      chk("fullpop_level", 64'(level), 64'd3);
      chk("fullpop_ready", 64'(rx_ready), 64'd1);
      cycle(1'b1, rand_data(), mk_user(4'h0, 4'h0, 4'h0), 1'b1);
      chk("pushpop_level", 64'(level), 64'd3);
      for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1);
      chk("drain2_level", 64'(level), 64'd0);

      // Four one-FLIT packets in a beat, then a header inside an open packet
      cycle(1'b1, rand_data(), mk_user(4'hF, 4'hF, 4'hF), 1'b1);
      chk("quad_pkt", 64'(pkt_count), STATS ? 64'd5 : 64'd0);
      chk("quad_err", 64'(err_proto), 64'd0);
      cycle(1'b1, rand_data(), mk_user(4'h1, 4'h1, 4'h0), 1'b1);
      chk("open_err", 64'(err_proto), 64'd0);
      cycle(1'b1, rand_data(), mk_user(4'h1, 4'h1, 4'h0), 1'b1);
      chk("dup_hdr_err", 64'(err_proto), STATS ? 64'd1 : 64'd0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("err_sticky", 64'(err_proto), STATS ? 64'd1 : 64'd0);

      // Reset mid-packet with three beats buffered
      for (int k = 0; k < 3; k++) cycle(1'b1, rand_data(), mk_user(4'h0, 4'h0, 4'h0), 1'b0);
      chk("pre_rst_level", 64'(level), 64'd3);
      @(negedge clk);
      #2 res = 1'b1;
      #1;
      mq.delete();
      m_in_pkt = 1'b0;
      m_count  = 0;
      m_err    = 1'b0;
      chk("arst_level", 64'(level), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_rx_ready", 64'(rx_ready), 64'd0);
      chk("arst_pkt", 64'(pkt_count), 64'd0);
      chk("arst_err", 64'(err_proto), 64'd0);
      repeat (2) @(posedge clk);
      #2 res = 1'b0;
      #1;
      chk("post_rst_ready", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1;

      // Random traffic with random flags and backpressure
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom % 4) != 0, rand_data(), {$urandom, $urandom}, ($urandom % 3) != 0);
      end

      // Drive the packet counter into saturation
      for (int k = 0; k < 16500; k++) begin
         cycle(1'b1, rand_data(), mk_user(4'hF, 4'hF, 4'hF), 1'b1);
      end
      chk("sat_pkt", 64'(pkt_count), STATS ? 64'hFFFF : 64'd0);
      cycle(1'b0, '0, '0, 1'b1);
      repeat (2) cycle(1'b0, '0, '0, 1'b1);
      chk("final_level", 64'(level), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
